// File: rtl/fault_recovery_sequencer.sv
// fault_recovery_sequencer: fault capture, reset-hold/cooldown recovery with bounded retries and sticky lockout
module fault_recovery_sequencer #(
    parameter int N_SRC         = 4,
    parameter int RESET_HOLD    = 4,
    parameter int COOLDOWN      = 16,
    parameter int MAX_RETRIES   = 3,
    parameter int STABLE_CYCLES = 64
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [N_SRC-1:0]                   fault_in,
    input  logic [N_SRC-1:0]                   fault_mask,
    input  logic                               clear_lockout,
    output logic                               fsm_reset,
    output logic                               ew_enable,
    output logic                               fault_event,
    output logic [$clog2(N_SRC)-1:0]           fault_src,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
    output logic                               lockout,
    output logic [1:0]                         seq_state
);
    localparam int IW = $clog2(N_SRC);
    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam int CW = $clog2((RESET_HOLD > COOLDOWN ? RESET_HOLD : COOLDOWN) + 1);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LD = CW'(RESET_HOLD - 1);
    localparam logic [CW-1:0] COOL_LD = CW'(COOLDOWN - 1);
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRIES);
    localparam logic [SW-1:0] SMAX = SW'(STABLE_CYCLES);

    typedef enum logic [1:0] {S_RUN = 2'd0, S_HOLD = 2'd1, S_COOL = 2'd2, S_LOCK = 2'd3} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [SW-1:0]   stable, stable_n;
    logic [RW-1:0]   retry_n;
    logic [IW-1:0]   src_n, pri;
    logic            event_n;
    logic [N_SRC-1:0] act;

    assign act = fault_in & ~fault_mask;

    always_comb begin
        pri = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (act[i]) pri = IW'(i);
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        retry_n  = retry_count;
        src_n    = fault_src;
        event_n  = 1'b0;
        stable_n = '0;
        case (state)
            S_RUN:
                if (|act) begin
                    src_n   = pri;
                    event_n = 1'b1;
                    if (retry_count == RMAX) begin
                        state_n = S_LOCK;
                    end else begin
                        state_n = S_HOLD;
                        retry_n = retry_count + RW'(1);
                        cnt_n   = HOLD_LD;
                    end
                end else begin
                    stable_n = (stable == SMAX) ? stable : stable + SW'(1);
                    retry_n  = (stable_n == SMAX) ? '0 : retry_count;
                end
            S_HOLD: begin
                state_n = (cnt == '0) ? S_COOL : S_HOLD;
                cnt_n   = (cnt == '0) ? COOL_LD : cnt - CW'(1);
            end
            S_COOL: begin
                state_n = (cnt == '0) ? S_RUN : S_COOL;
                cnt_n   = (cnt == '0) ? cnt : cnt - CW'(1);
            end
            S_LOCK:
                if (clear_lockout) begin
                    state_n = S_HOLD;
                    retry_n = '0;
                    cnt_n   = HOLD_LD;
                end
            default: state_n = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_RUN;
            cnt         <= '0;
            stable      <= '0;
            retry_count <= '0;
            fault_src   <= '0;
            fault_event <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            stable      <= stable_n;
            retry_count <= retry_n;
            fault_src   <= src_n;
            fault_event <= event_n;
        end
    end

    assign fsm_reset = (state == S_HOLD) || (state == S_LOCK);
    assign ew_enable = ~fsm_reset;
    assign lockout   = (state == S_LOCK);
    assign seq_state = state;
endmodule

// File: tb/tb_fault_recovery_sequencer.sv
// tb_fault_recovery_sequencer: vector table plus hand-written recovery, lockout and refund sequences
module tb_fault_recovery_sequencer;
    localparam logic [1:0] RUN = 2'd0, HOLD = 2'd1, COOL = 2'd2, LOCK = 2'd3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] fault_in = '0;
    logic [3:0] fault_mask = '0;
    logic       clear_lockout = 1'b0;
    logic       fsm_reset, ew_enable, fault_event, lockout;
    logic [1:0] fault_src, retry_count, seq_state;

    fault_recovery_sequencer dut (
        .clk(clk), .reset_n(reset_n), .fault_in(fault_in), .fault_mask(fault_mask),
        .clear_lockout(clear_lockout), .fsm_reset(fsm_reset), .ew_enable(ew_enable),
        .fault_event(fault_event), .fault_src(fault_src), .retry_count(retry_count),
        .lockout(lockout), .seq_state(seq_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] fi;
        logic [3:0] fm;
        logic       clr;
        logic [1:0] st;
        logic       ev;
        logic [1:0] src;
        logic [1:0] rc;
    } vec_t;

    vec_t exp_q[$];
    vec_t tab[6];
    int tests = 0;
    int fails = 0;

    function automatic vec_t mk(logic [3:0] fi, logic [3:0] fm, logic clr,
                                logic [1:0] st, logic ev, logic [1:0] src, logic [1:0] rc);
        vec_t v;
        v.fi = fi; v.fm = fm; v.clr = clr; v.st = st; v.ev = ev; v.src = src; v.rc = rc;
        return v;
    endfunction

    task automatic check(input string name, input vec_t e);
        logic [10:0] act, req;
        act = {seq_state, fsm_reset, ew_enable, fault_event, fault_src, retry_count, lockout};
        req = {e.st, (e.st == HOLD || e.st == LOCK), (e.st == RUN || e.st == COOL),
               e.ev, e.src, e.rc, (e.st == LOCK)};
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got {st,rst,en,ev,src,rc,lock}=%b want %b", name, act, req);
        end
    endtask

    task automatic apply(input string name, input vec_t v);
        vec_t e;
        @(negedge clk);
        fault_in = v.fi;
        fault_mask = v.fm;
        clear_lockout = v.clr;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            check(name, e);
        end
    endtask

    task automatic tail(input string name, input logic [3:0] fi, input logic [1:0] src, input logic [1:0] rc);
        repeat (3) apply({name, "_hold"}, mk(fi, 4'b0, 1'b0, HOLD, 1'b0, src, rc));
        repeat (16) apply({name, "_cool"}, mk(fi, 4'b0, 1'b0, COOL, 1'b0, src, rc));
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        reset_n = 1'b0;
        fault_in = '0;
        fault_mask = '0;
        clear_lockout = 1'b0;
        #1;
        check(name, mk(4'b0, 4'b0, 1'b0, RUN, 1'b0, 2'd0, 2'd0));
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        tab[0] = mk(4'b0001, 4'b0000, 1'b0, HOLD, 1'b1, 2'd0, 2'd1);
        tab[1] = mk(4'b1010, 4'b0000, 1'b0, HOLD, 1'b1, 2'd1, 2'd1);
        tab[2] = mk(4'b1010, 4'b0010, 1'b0, HOLD, 1'b1, 2'd3, 2'd1);
        tab[3] = mk(4'b1010, 4'b1010, 1'b0, RUN,  1'b0, 2'd0, 2'd0);
        tab[4] = mk(4'b1100, 4'b0100, 1'b0, HOLD, 1'b1, 2'd3, 2'd1);
        tab[5] = mk(4'b0000, 4'b1111, 1'b1, RUN,  1'b0, 2'd0, 2'd0);

        #1;
        check("reset_initial", mk(4'b0, 4'b0, 1'b0, RUN, 1'b0, 2'd0, 2'd0));
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 100; i++)
            apply("idle", mk(4'b0, 4'b0, 1'b0, RUN, 1'b0, 2'd0, 2'd0));

        for (int i = 0; i < 6; i++) begin
            do_reset("reset_in_hold");
            apply($sformatf("table%0d", i), tab[i]);
        end

        // recoveries back to back, then lockout and clear racing a fault
        do_reset("reset_seq_a");
        apply("clr_in_run", mk(4'b0, 4'b0, 1'b1, RUN, 1'b0, 2'd0, 2'd0));
        apply("cap1", mk(4'b0001, 4'b0, 1'b0, HOLD, 1'b1, 2'd0, 2'd1));
        tail("rec1", 4'b0100, 2'd0, 2'd1);
        apply("rearm_ignored", mk(4'b0100, 4'b0, 1'b0, RUN, 1'b0, 2'd0, 2'd1));
        apply("cap2_held", mk(4'b0100, 4'b0, 1'b0, HOLD, 1'b1, 2'd2, 2'd2));
        tail("rec2", 4'b0100, 2'd2, 2'd2);
        apply("run2", mk(4'b0, 4'b0, 1'b0, RUN, 1'b0, 2'd2, 2'd2));
        apply("cap3", mk(4'b1000, 4'b0, 1'b0, HOLD, 1'b1, 2'd3, 2'd3));
        tail("rec3", 4'b0, 2'd3, 2'd3);
        apply("run3", mk(4'b0, 4'b0, 1'b0, RUN, 1'b0, 2'd3, 2'd3));
        apply("cap4_lock", mk(4'b0010, 4'b0, 1'b0, LOCK, 1'b1, 2'd1, 2'd3));
        repeat (5) apply("lock_stay", mk(4'b0001, 4'b0, 1'b0, LOCK, 1'b0, 2'd1, 2'd3));
        apply("clr_vs_fault", mk(4'b0001, 4'b0, 1'b1, HOLD, 1'b0, 2'd1, 2'd0));
        tail("rec_clr", 4'b0, 2'd1, 2'd0);
        apply("run_after_clr", mk(4'b0, 4'b0, 1'b0, RUN, 1'b0, 2'd1, 2'd0));

        // refund after exactly 64 clean RUN cycles
        do_reset("reset_seq_b");
        apply("r_cap1", mk(4'b0001, 4'b0, 1'b0, HOLD, 1'b1, 2'd0, 2'd1));
        tail("r_rec1", 4'b0, 2'd0, 2'd1);
        apply("r_run1", mk(4'b0, 4'b0, 1'b0, RUN, 1'b0, 2'd0, 2'd1));
        repeat (10) apply("r_clean1", mk(4'b0, 4'b0, 1'b0, RUN, 1'b0, 2'd0, 2'd1));
        apply("r_cap2", mk(4'b0010, 4'b0, 1'b0, HOLD, 1'b1, 2'd1, 2'd2));
        tail("r_rec2", 4'b0, 2'd1, 2'd2);
        apply("r_run2", mk(4'b0, 4'b0, 1'b0, RUN, 1'b0, 2'd1, 2'd2));
        repeat (63) apply("r_pre_refund", mk(4'b0, 4'b0, 1'b0, RUN, 1'b0, 2'd1, 2'd2));
        apply("r_refund", mk(4'b0, 4'b0, 1'b0, RUN, 1'b0, 2'd1, 2'd0));
        repeat (5) apply("r_saturated", mk(4'b0, 4'b0, 1'b0, RUN, 1'b0, 2'd1, 2'd0));

        // fault on the refund edge wins, then lockout and async reset there
        do_reset("reset_seq_c");
        apply("n_cap1", mk(4'b0001, 4'b0, 1'b0, HOLD, 1'b1, 2'd0, 2'd1));
        tail("n_rec1", 4'b0, 2'd0, 2'd1);
        apply("n_run1", mk(4'b0, 4'b0, 1'b0, RUN, 1'b0, 2'd0, 2'd1));
        apply("n_cap2", mk(4'b0001, 4'b0, 1'b0, HOLD, 1'b1, 2'd0, 2'd2));
        tail("n_rec2", 4'b0, 2'd0, 2'd2);
        apply("n_run2", mk(4'b0, 4'b0, 1'b0, RUN, 1'b0, 2'd0, 2'd2));
        repeat (63) apply("n_clean", mk(4'b0, 4'b0, 1'b0, RUN, 1'b0, 2'd0, 2'd2));
        apply("n_fault_at_64", mk(4'b0100, 4'b0, 1'b0, HOLD, 1'b1, 2'd2, 2'd3));
        tail("n_rec3", 4'b0, 2'd2, 2'd3);
        apply("n_run3", mk(4'b0, 4'b0, 1'b0, RUN, 1'b0, 2'd2, 2'd3));
        apply("n_lock", mk(4'b1000, 4'b0, 1'b0, LOCK, 1'b1, 2'd3, 2'd3));
        do_reset("reset_in_lock");
        apply("post_reset", mk(4'b0, 4'b0, 1'b0, RUN, 1'b0, 2'd0, 2'd0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
